// File: rtl/alu_arbiter.sv
// Round-robin two-requester front end for a shared combinational 8-bit ALU.
// Optional per-requester grant counters are enabled with ALU_ARB_STATS_EN.
module alu_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [7:0] req_a0,
  input  logic [7:0] req_b0,
  input  logic [2:0] req_op0,
  input  logic [7:0] req_a1,
  input  logic [7:0] req_b1,
  input  logic [2:0] req_op1,
  output logic [1:0] rsp_valid,
  input  logic [1:0] rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_carry,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
`ifdef ALU_ARB_STATS_EN
  output logic [7:0] grant_cnt0,
  output logic [7:0] grant_cnt1,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] EXEC_INIT = 4'(EXEC_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_exec_cnt;
  logic       r_owner;
  logic       r_rr_last;
  logic [1:0] r_rsp_valid;
  logic [7:0] r_rsp_data;
  logic       r_rsp_carry;
  logic [7:0] r_alu_a;
  logic [7:0] r_alu_b;
  logic [2:0] r_alu_sel;

  logic       w_grant;
  logic [1:0] w_req_ready;
  logic       w_fire;

  // On contention the requester that did not complete last wins.
  always_comb begin
    w_grant = req_valid[1];
    if (req_valid == 2'b11) begin
      w_grant = ~r_rr_last;
    end
  end

  always_comb begin
    w_req_ready = 2'b00;
    if (r_state == IDLE) begin
      w_req_ready = (w_grant ? 2'b10 : 2'b01) & req_valid;
    end
  end

  assign w_fire = |w_req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_exec_cnt  <= 4'd0;
      r_owner     <= 1'b0;
      r_rr_last   <= 1'b1;
      r_rsp_valid <= 2'b00;
      r_rsp_data  <= 8'h00;
      r_rsp_carry <= 1'b0;
      r_alu_a     <= 8'h00;
      r_alu_b     <= 8'h00;
      r_alu_sel   <= 3'b000;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fire) begin
            r_alu_a    <= w_grant ? req_a1 : req_a0;
            r_alu_b    <= w_grant ? req_b1 : req_b0;
            r_alu_sel  <= w_grant ? req_op1 : req_op0;
            r_owner    <= w_grant;
            r_exec_cnt <= EXEC_INIT;
            r_state    <= EXEC;
          end
        end
        EXEC: begin
          if (r_exec_cnt != 4'd0) begin
            r_exec_cnt <= r_exec_cnt - 4'd1;
          end else begin
            r_rsp_data  <= alu_out;
            r_rsp_carry <= alu_carry;
            r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
            r_state     <= RESP;
          end
        end
        RESP: begin
          // Only the owner's accept matters; a new request waits for IDLE.
          if (rsp_ready[r_owner]) begin
            r_rr_last   <= r_owner;
            r_rsp_valid <= 2'b00;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [7:0] r_grant_cnt0;
  logic [7:0] r_grant_cnt1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_grant_cnt0 <= 8'd0;
      r_grant_cnt1 <= 8'd0;
    end else if (w_fire) begin
      if (!w_grant && r_grant_cnt0 != 8'hFF) begin
        r_grant_cnt0 <= r_grant_cnt0 + 8'd1;
      end
      if (w_grant && r_grant_cnt1 != 8'hFF) begin
        r_grant_cnt1 <= r_grant_cnt1 + 8'd1;
      end
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
`endif

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_carry = r_rsp_carry;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_sel   = r_alu_sel;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with EXEC_CYCLES=1, one with 4.
// Grant-counter checks run only when ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference ALU driven by the registered operands of each instance.
  function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
    case (op)
      3'b000:  alu_model = {1'b0, a} + {1'b0, b};
      3'b001:  alu_model = {1'b0, a} - {1'b0, b};
      3'b010:  alu_model = {1'b0, a & b};
      3'b011:  alu_model = {1'b0, a | b};
      3'b100:  alu_model = {1'b0, a ^ b};
      3'b101:  alu_model = {a, 1'b0};
      3'b110:  alu_model = {a[0], 1'b0, a[7:1]};
      default: alu_model = {(a < b), a - b};
    endcase
  endfunction

  // ---------------- instance with EXEC_CYCLES = 1 ----------------
  logic       reset;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0] req_a0, req_b0, req_a1, req_b1, rsp_data, alu_a, alu_b, alu_out;
  logic [2:0] req_op0, req_op1, alu_sel;
  logic       rsp_carry, alu_carry, busy;
`ifdef ALU_ARB_STATS_EN
  logic [7:0] grant_cnt0, grant_cnt1;
`endif

  assign {alu_carry, alu_out} = alu_model(alu_a, alu_b, alu_sel);

  alu_arbiter #(.EXEC_CYCLES(1)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
    .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
`endif
    .busy(busy)
  );

  // ---------------- instance with EXEC_CYCLES = 4 ----------------
  logic       reset_4;
  logic [1:0] req_valid_4, req_ready_4, rsp_valid_4, rsp_ready_4;
  logic [7:0] req_a0_4, req_b0_4, req_a1_4, req_b1_4, rsp_data_4, alu_a_4, alu_b_4, alu_out_4;
  logic [2:0] req_op0_4, req_op1_4, alu_sel_4;
  logic       rsp_carry_4, alu_carry_4, busy_4;
`ifdef ALU_ARB_STATS_EN
  logic [7:0] grant_cnt0_4, grant_cnt1_4;
`endif

  assign {alu_carry_4, alu_out_4} = alu_model(alu_a_4, alu_b_4, alu_sel_4);

  alu_arbiter #(.EXEC_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(reset_4),
    .req_valid(req_valid_4), .req_ready(req_ready_4),
    .req_a0(req_a0_4), .req_b0(req_b0_4), .req_op0(req_op0_4),
    .req_a1(req_a1_4), .req_b1(req_b1_4), .req_op1(req_op1_4),
    .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready_4),
    .rsp_data(rsp_data_4), .rsp_carry(rsp_carry_4),
    .alu_a(alu_a_4), .alu_b(alu_b_4), .alu_sel(alu_sel_4),
    .alu_out(alu_out_4), .alu_carry(alu_carry_4),
`ifdef ALU_ARB_STATS_EN
    .grant_cnt0(grant_cnt0_4), .grant_cnt1(grant_cnt1_4),
`endif
    .busy(busy_4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; reset_4 = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req_a0 = 8'h00; req_b0 = 8'h00; req_op0 = 3'b000;
    req_a1 = 8'h00; req_b1 = 8'h00; req_op1 = 3'b000;
    req_valid_4 = 2'b00; rsp_ready_4 = 2'b00;
    req_a0_4 = 8'h00; req_b0_4 = 8'h00; req_op0_4 = 3'b000;
    req_a1_4 = 8'h00; req_b1_4 = 8'h00; req_op1_4 = 3'b000;

    // Reset values
    tick(); tick();
    @(negedge clk);
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_rsp_carry", rsp_carry, 1'b0);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_alu_b", alu_b, 8'h00);
    chk("rst_alu_sel", alu_sel, 3'b000);
    chk("rst_busy", busy, 1'b0);
    tick();
    reset = 1'b1; reset_4 = 1'b1;

    // Single request from requester 0: 0x0F + 0x01
    tick();
    req_valid = 2'b01; req_a0 = 8'h0F; req_b0 = 8'h01; req_op0 = 3'b000; rsp_ready = 2'b11;
    @(negedge clk);
    chk("t1_req_ready_T", req_ready, 2'b01);
    chk("t1_busy_T", busy, 1'b0);
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("t1_busy_T1", busy, 1'b1);
    chk("t1_alu_a", alu_a, 8'h0F);
    chk("t1_alu_b", alu_b, 8'h01);
    chk("t1_alu_sel", alu_sel, 3'b000);
    chk("t1_rsp_valid_T1", rsp_valid, 2'b00);
    tick();
    @(negedge clk);
    chk("t1_rsp_valid_T2", rsp_valid, 2'b01);
    chk("t1_rsp_data", rsp_data, 8'h10);
    chk("t1_rsp_carry", rsp_carry, 1'b0);
    tick();
    @(negedge clk);
    chk("t1_busy_T3", busy, 1'b0);
    chk("t1_rsp_valid_T3", rsp_valid, 2'b00);

    // Contention right after reset: requester 0 first, then requester 1
    pulse_reset();
    tick();
    req_valid = 2'b11;
    req_a0 = 8'hFF; req_b0 = 8'h01; req_op0 = 3'b000;
    req_a1 = 8'hAA; req_b1 = 8'h0F; req_op1 = 3'b100;
    @(negedge clk);
    chk("t2_grant0", req_ready, 2'b01);
    tick();
    req_valid = 2'b10;
    @(negedge clk);
    chk("t2_ready_exec", req_ready, 2'b00);
    tick();
    @(negedge clk);
    chk("t2_rsp_valid0", rsp_valid, 2'b01);
    chk("t2_rsp_data0", rsp_data, 8'h00);
    chk("t2_rsp_carry0", rsp_carry, 1'b1);
    tick();
    @(negedge clk);
    chk("t2_grant1", req_ready, 2'b10);
    chk("t2_busy_idle", busy, 1'b0);
    tick();
    req_valid = 2'b00;
    tick();
    @(negedge clk);
    chk("t2_rsp_valid1", rsp_valid, 2'b10);
    chk("t2_rsp_data1", rsp_data, 8'hA5);
    chk("t2_rsp_carry1", rsp_carry, 1'b0);
    tick();

    // Continuous contention: strict alternation, one grant every 3 cycles
    req_valid = 2'b11;
    req_a0 = 8'h10; req_b0 = 8'h20; req_op0 = 3'b000;
    req_a1 = 8'h33; req_b1 = 8'h0F; req_op1 = 3'b100;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("t3_grant_%0d", k), req_ready, (k % 2) ? 2'b10 : 2'b01);
      tick(); tick();
      @(negedge clk);
      chk($sformatf("t3_rsp_valid_%0d", k), rsp_valid, (k % 2) ? 2'b10 : 2'b01);
      chk($sformatf("t3_rsp_data_%0d", k), rsp_data, (k % 2) ? 8'h3C : 8'h30);
      tick();
    end

    // Response back-pressure and non-owner accept
    req_valid = 2'b01; req_a0 = 8'h05; req_b0 = 8'h03; req_op0 = 3'b000; rsp_ready = 2'b00;
    @(negedge clk);
    chk("t4_grant0", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    tick();
    for (int i = 0; i < 5; i++) begin
      req_valid = 2'b10;
      rsp_ready = (i == 2) ? 2'b10 : 2'b00;
      @(negedge clk);
      chk($sformatf("t4_hold_valid_%0d", i), rsp_valid, 2'b01);
      chk($sformatf("t4_hold_data_%0d", i), rsp_data, 8'h08);
      chk($sformatf("t4_hold_ready_%0d", i), req_ready, 2'b00);
      chk($sformatf("t4_hold_busy_%0d", i), busy, 1'b1);
      tick();
    end
    rsp_ready = 2'b01; req_valid = 2'b10;
    @(negedge clk);
    chk("t4_no_grant_in_resp", req_ready, 2'b00);
    chk("t4_valid_at_accept", rsp_valid, 2'b01);
    tick();
    @(negedge clk);
    chk("t4_busy_after", busy, 1'b0);
    chk("t4_rsp_cleared", rsp_valid, 2'b00);
    chk("t4_grant1", req_ready, 2'b10);
    tick();
    req_valid = 2'b00; rsp_ready = 2'b11;
    tick();
    @(negedge clk);
    chk("t4_rsp_valid1", rsp_valid, 2'b10);
    chk("t4_rsp_data1", rsp_data, 8'h3C);
    tick();

    // EXEC_CYCLES=4: latency, then asynchronous reset mid-operation
    req_valid_4 = 2'b01; req_a0_4 = 8'h12; req_b0_4 = 8'h34; req_op0_4 = 3'b000; rsp_ready_4 = 2'b11;
    @(negedge clk);
    chk("t5_grant0", req_ready_4, 2'b01);
    tick();
    req_valid_4 = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("t5_exec_valid_%0d", i), rsp_valid_4, 2'b00);
      chk($sformatf("t5_exec_busy_%0d", i), busy_4, 1'b1);
      tick();
    end
    @(negedge clk);
    chk("t5_rsp_valid", rsp_valid_4, 2'b01);
    chk("t5_rsp_data", rsp_data_4, 8'h46);
    tick();
    req_valid_4 = 2'b10; req_a1_4 = 8'h77; req_b1_4 = 8'h11; req_op1_4 = 3'b010;
    @(negedge clk);
    chk("t5_grant1", req_ready_4, 2'b10);
    tick();
    req_valid_4 = 2'b00;
    tick();
    reset_4 = 1'b0;
    #1;
    chk("t5_rst_req_ready", req_ready_4, 2'b00);
    chk("t5_rst_rsp_valid", rsp_valid_4, 2'b00);
    chk("t5_rst_rsp_data", rsp_data_4, 8'h00);
    chk("t5_rst_rsp_carry", rsp_carry_4, 1'b0);
    chk("t5_rst_alu_a", alu_a_4, 8'h00);
    chk("t5_rst_alu_b", alu_b_4, 8'h00);
    chk("t5_rst_alu_sel", alu_sel_4, 3'b000);
    chk("t5_rst_busy", busy_4, 1'b0);
    tick();
    reset_4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("t5_no_rsp_%0d", i), rsp_valid_4, 2'b00);
      tick();
    end
    req_valid_4 = 2'b11;
    req_a0_4 = 8'h01; req_b0_4 = 8'h01; req_op0_4 = 3'b000;
    @(negedge clk);
    chk("t5_grant_after_rst", req_ready_4, 2'b01);
    tick();
    req_valid_4 = 2'b00;

`ifdef ALU_ARB_STATS_EN
    // Grant counters: 300 back-to-back requester-0 operations
    pulse_reset();
    @(negedge clk);
    chk("t6_cnt0_reset", grant_cnt0, 8'd0);
    chk("t6_cnt1_reset", grant_cnt1, 8'd0);
    req_valid = 2'b01; rsp_ready = 2'b11;
    repeat (30) tick();
    @(negedge clk);
    chk("t6_cnt0_10", grant_cnt0, 8'd10);
    repeat (870) tick();
    req_valid = 2'b00;
    @(negedge clk);
    chk("t6_cnt0_sat", grant_cnt0, 8'd255);
    chk("t6_cnt1_zero", grant_cnt1, 8'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
